// File: rtl/rmt_pkt_arbiter_if.sv
// Ingress bundle (NUM_PORTS AXI-Stream slaves) and merged egress stream of rmt_pkt_arbiter.
// master drives the ingress ports and sinks the egress; slave is the arbiter itself.
interface rmt_pkt_arbiter_if #(
  parameter int DW        = 512,
  parameter int UW        = 128,
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS*DW-1:0]   s_axis_tdata;
  logic [NUM_PORTS*DW/8-1:0] s_axis_tkeep;
  logic [NUM_PORTS*UW-1:0]   s_axis_tuser;
  logic [NUM_PORTS-1:0]      s_axis_tvalid;
  logic [NUM_PORTS-1:0]      s_axis_tlast;
  logic [NUM_PORTS-1:0]      s_axis_tready;

  logic [DW-1:0]             m_axis_tdata;
  logic [DW/8-1:0]           m_axis_tkeep;
  logic [UW-1:0]             m_axis_tuser;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic                      m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );
endinterface

// File: rtl/rmt_pkt_arbiter.sv
// Packet-granular N:1 AXI-Stream arbiter feeding the RMT pipeline through one output register.
// Port 0 optionally has strict priority between packets; other ports are served round-robin.
module rmt_pkt_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter bit CTRL_PRIO            = 1'b1
) (
  input  logic                         clk,
  input  logic                         aresetn,
  rmt_pkt_arbiter_if.slave             axis,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic [NUM_PORTS*32-1:0]      pkt_cnt
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        sel;
  logic [GW-1:0]        src;
  logic [GW-1:0]        nxt_ptr;
  logic                 found;
  logic                 adv;
  logic                 take;
  logic [NUM_PORTS-1:0] ready;
  logic [31:0]          cnt [NUM_PORTS];
  int                   idx;

  // Winner for a packet start: round-robin scan from rr_ptr, overridden by port 0 when enabled.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && axis.s_axis_tvalid[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    if (CTRL_PRIO && axis.s_axis_tvalid[0]) begin
      sel   = '0;
      found = 1'b1;
    end
  end

  // Only one port is ever offered a ready: the arbitration winner in IDLE, the owner in BUSY.
  always_comb begin
    adv   = ~axis.m_axis_tvalid | axis.m_axis_tready;
    src   = (state == IDLE) ? sel : grant_id;
    ready = '0;
    if (aresetn && ((state == BUSY) || found)) ready[src] = adv;
  end

  assign axis.s_axis_tready = ready;
  assign take               = |(ready & axis.s_axis_tvalid);
  assign nxt_ptr            = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      grant_id           <= '0;
      busy               <= 1'b0;
      axis.m_axis_tvalid <= 1'b0;
      axis.m_axis_tlast  <= 1'b0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tkeep  <= '0;
      axis.m_axis_tuser  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else if (take) begin
      axis.m_axis_tdata  <= axis.s_axis_tdata[int'(src)*DW +: DW];
      axis.m_axis_tkeep  <= axis.s_axis_tkeep[int'(src)*KW +: KW];
      axis.m_axis_tuser  <= axis.s_axis_tuser[int'(src)*UW +: UW];
      axis.m_axis_tlast  <= axis.s_axis_tlast[src];
      axis.m_axis_tvalid <= 1'b1;
      if (state == IDLE) begin
        grant_id <= sel;
        rr_ptr   <= nxt_ptr;
      end
      if (axis.s_axis_tlast[src]) begin
        state    <= IDLE;
        busy     <= 1'b0;
        cnt[src] <= cnt[src] + 32'd1;
      end else begin
        state <= BUSY;
        busy  <= 1'b1;
      end
    end else if (axis.m_axis_tready) begin
      axis.m_axis_tvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_cnt[i*32 +: 32] = cnt[i];
  end
endmodule

// File: tb/tb_rmt_pkt_arbiter.sv
// Directed bench for rmt_pkt_arbiter: one round-robin instance and one with port-0 priority.
module tb_rmt_pkt_arbiter;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int N  = 4;
  localparam int KW = DW / 8;
  localparam int GW = 2;
  localparam int BW = DW + KW + UW + 1;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  rmt_pkt_arbiter_if #(.DW(DW), .UW(UW), .NUM_PORTS(N)) ifa ();
  rmt_pkt_arbiter_if #(.DW(DW), .UW(UW), .NUM_PORTS(N)) ifb ();

  logic [GW-1:0]   grant_a, grant_b;
  logic            busy_a, busy_b;
  logic [N*32-1:0] cnt_a, cnt_b;

  rmt_pkt_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(N), .CTRL_PRIO(1'b0)) u_rr (
    .clk(clk), .aresetn(aresetn), .axis(ifa), .grant_id(grant_a), .busy(busy_a), .pkt_cnt(cnt_a));
  rmt_pkt_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(N), .CTRL_PRIO(1'b1)) u_cp (
    .clk(clk), .aresetn(aresetn), .axis(ifb), .grant_id(grant_b), .busy(busy_b), .pkt_cnt(cnt_b));

  int passed = 0;
  int total  = 0;
  int lens [N][500];

  function automatic logic [DW-1:0] mk_data(int p, int pkt, int beat);
    return {16'(p), 32'(pkt), 16'(beat)};
  endfunction
  function automatic logic [BW-1:0] beat_of(int p, int pkt, int beat, bit last);
    return {mk_data(p, pkt, beat), KW'(p*37 + beat*11 + 1), UW'(pkt*3 + p*1000 + 7), last};
  endfunction
  function automatic logic [BW-1:0] out_a();
    return {ifa.m_axis_tdata, ifa.m_axis_tkeep, ifa.m_axis_tuser, ifa.m_axis_tlast};
  endfunction
  function automatic logic [BW-1:0] out_b();
    return {ifb.m_axis_tdata, ifb.m_axis_tkeep, ifb.m_axis_tuser, ifb.m_axis_tlast};
  endfunction

  // Same stimulus goes to both instances; each test observes only the one it targets.
  task automatic drive(input int p, input bit v, input int pkt, input int beat, input bit last);
    logic [BW-1:0] b;
    b = beat_of(p, pkt, beat, last);
    ifa.s_axis_tvalid[p] = v;                   ifb.s_axis_tvalid[p] = v;
    ifa.s_axis_tlast[p]  = last;                ifb.s_axis_tlast[p]  = last;
    ifa.s_axis_tdata[p*DW +: DW] = b[BW-1 -: DW]; ifb.s_axis_tdata[p*DW +: DW] = b[BW-1 -: DW];
    ifa.s_axis_tkeep[p*KW +: KW] = b[UW+KW:UW+1]; ifb.s_axis_tkeep[p*KW +: KW] = b[UW+KW:UW+1];
    ifa.s_axis_tuser[p*UW +: UW] = b[UW:1];       ifb.s_axis_tuser[p*UW +: UW] = b[UW:1];
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < N; p++) drive(p, 1'b0, 0, 0, 1'b0);
    ifa.m_axis_tready = 1'b1;
    ifb.m_axis_tready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    aresetn = 1'b0;
    repeat (2) next_cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    aresetn = 1'b0;
    drive(1, 1'b1, 0, 0, 1'b1);
    repeat (2) next_cycle();
    @(negedge clk);
    total++; if (ifa.s_axis_tready !== 4'b0) $display("FAIL reset_tready got %b want 0000", ifa.s_axis_tready); else passed++;
    total++; if (ifa.m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", ifa.m_axis_tvalid); else passed++;
    total++; if (out_a() !== '0) $display("FAIL reset_out_beat got %h want 0", out_a()); else passed++;
    total++; if (grant_a !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else passed++;
    total++; if (cnt_a !== '0) $display("FAIL reset_pkt_cnt got %h want 0", cnt_a); else passed++;
    next_cycle();
    clear_inputs();
    aresetn = 1'b1;
  endtask

  task automatic test_single_port();
    logic [N-1:0] hs;
    int sent, got, first, last;
    do_reset();
    sent = 0; got = 0; first = -1; last = -1;
    drive(2, 1'b1, 0, 0, 1'b1);
    for (int c = 0; c < 1100 && got < 1000; c++) begin
      @(negedge clk);
      hs = ifa.s_axis_tvalid & ifa.s_axis_tready;
      if (ifa.m_axis_tvalid) begin
        total++;
        if (out_a() !== beat_of(2, got, 0, 1'b1)) $display("FAIL single_beat%0d got %h want %h", got, out_a(), beat_of(2, got, 0, 1'b1));
        else passed++;
        if (first < 0) first = c;
        last = c;
        got++;
      end
      next_cycle();
      if (hs[2]) begin
        sent++;
        drive(2, sent < 1000, sent, 0, 1'b1);
      end
    end
    total++; if (got != 1000) $display("FAIL single_count got %0d want 1000", got); else passed++;
    total++; if (first != 1) $display("FAIL single_first_cycle got %0d want 1", first); else passed++;
    total++; if (last != 1000) $display("FAIL single_last_cycle got %0d want 1000", last); else passed++;
    total++; if (cnt_a[64 +: 32] !== 32'd1000) $display("FAIL single_pkt_cnt2 got %0d want 1000", cnt_a[64 +: 32]); else passed++;
    total++; if (cnt_a[0 +: 32] !== 32'd0) $display("FAIL single_pkt_cnt0 got %0d want 0", cnt_a[0 +: 32]); else passed++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] hs;
    int sent [N];
    int got, last;
    do_reset();
    got = 0; last = -1;
    for (int p = 0; p < N; p++) begin sent[p] = 0; drive(p, 1'b1, 0, 0, 1'b1); end
    for (int c = 0; c < 600 && got < 400; c++) begin
      @(negedge clk);
      hs = ifa.s_axis_tvalid & ifa.s_axis_tready;
      if (ifa.m_axis_tvalid) begin
        total++;
        if (out_a() !== beat_of(got % 4, got / 4, 0, 1'b1) || grant_a !== GW'(got % 4))
          $display("FAIL rr_order beat%0d got %h grant %0d want %h grant %0d", got, out_a(), grant_a, beat_of(got % 4, got / 4, 0, 1'b1), got % 4);
        else passed++;
        last = c;
        got++;
      end
      next_cycle();
      for (int p = 0; p < N; p++) if (hs[p]) begin sent[p]++; drive(p, sent[p] < 100, sent[p], 0, 1'b1); end
    end
    total++; if (last != 400) $display("FAIL rr_last_cycle got %0d want 400", last); else passed++;
    for (int p = 0; p < N; p++) begin
      total++; if (cnt_a[p*32 +: 32] !== 32'd100) $display("FAIL rr_pkt_cnt%0d got %0d want 100", p, cnt_a[p*32 +: 32]); else passed++;
    end
  endtask

  task automatic test_atomicity();
    logic [N-1:0] hs;
    logic [BW-1:0] exp;
    int b1, got;
    do_reset();
    b1 = 0; got = 0;
    drive(1, 1'b1, 0, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hs = ifa.s_axis_tvalid & ifa.s_axis_tready;
      if (c >= 1 && c <= 4) begin
        total++; if (ifa.s_axis_tready[3] !== 1'b0 || busy_a !== 1'b1) $display("FAIL atom_hold c%0d got ready3 %b busy %b want 0 1", c, ifa.s_axis_tready[3], busy_a); else passed++;
      end
      if (ifa.m_axis_tvalid) begin
        exp = (got < 5) ? beat_of(1, 0, got, got == 4) : beat_of(3, 0, 0, 1'b1);
        total++;
        if (out_a() !== exp || c != got + 1) $display("FAIL atom_beat%0d got %h at c%0d want %h at c%0d", got, out_a(), c, exp, got + 1);
        else passed++;
        got++;
      end
      next_cycle();
      if (hs[1]) begin b1++; drive(1, b1 < 5, 0, b1, b1 == 4); end
      if (c == 0) drive(3, 1'b1, 0, 0, 1'b1);
      if (hs[3]) drive(3, 1'b0, 0, 0, 1'b0);
    end
    total++; if (got != 6) $display("FAIL atom_count got %0d want 6", got); else passed++;
  endtask

  task automatic test_ctrl_prio();
    logic [N-1:0] hs;
    logic [BW-1:0] exp;
    int ep [6] = '{2, 2, 2, 0, 0, 1};
    int ek [6] = '{0, 0, 0, 0, 1, 0};
    int eb [6] = '{0, 1, 2, 0, 0, 0};
    int b2, n0, got;
    do_reset();
    b2 = 0; n0 = 0; got = 0;
    drive(2, 1'b1, 0, 0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      hs = ifb.s_axis_tvalid & ifb.s_axis_tready;
      if (c <= 2) begin
        total++; if (ifb.s_axis_tready !== 4'b0100) $display("FAIL prio_ready c%0d got %b want 0100", c, ifb.s_axis_tready); else passed++;
      end
      if (ifb.m_axis_tvalid && got < 6) begin
        exp = beat_of(ep[got], ek[got], eb[got], ep[got] != 2 || eb[got] == 2);
        total++;
        if (out_b() !== exp || grant_b !== GW'(ep[got]) || c != got + 1)
          $display("FAIL prio_beat%0d got %h grant %0d c%0d want %h grant %0d c%0d", got, out_b(), grant_b, c, exp, ep[got], got + 1);
        else passed++;
        got++;
      end
      next_cycle();
      if (hs[2]) begin b2++; drive(2, b2 < 3, 0, b2, b2 == 2); end
      if (c == 0) begin drive(0, 1'b1, 0, 0, 1'b1); drive(1, 1'b1, 0, 0, 1'b1); end
      if (hs[0]) begin n0++; drive(0, n0 < 2, n0, 0, 1'b1); end
      if (hs[1]) drive(1, 1'b0, 0, 0, 1'b0);
    end
    total++; if (got != 6) $display("FAIL prio_count got %0d want 6", got); else passed++;
    total++; if (cnt_b[0 +: 32] !== 32'd2) $display("FAIL prio_pkt_cnt0 got %0d want 2", cnt_b[0 +: 32]); else passed++;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] hs;
    logic [BW-1:0] prev, exp;
    int src_pkt [N], src_beat [N], sb_pkt [N], sb_beat [N];
    int open_p, need, got, p;
    bit held;
    do_reset();
    need = 0; got = 0; open_p = -1; held = 1'b0; prev = '0;
    for (int q = 0; q < N; q++) begin
      src_pkt[q] = 0; src_beat[q] = 0; sb_pkt[q] = 0; sb_beat[q] = 0;
      for (int k = 0; k < 500; k++) begin lens[q][k] = int'($urandom_range(1, 4)); need += lens[q][k]; end
    end
    for (int c = 0; c < 40000 && got < need; c++) begin
      @(negedge clk);
      hs = ifa.s_axis_tvalid & ifa.s_axis_tready;
      if (held) begin
        total++; if (ifa.m_axis_tvalid !== 1'b1 || out_a() !== prev) $display("FAIL bp_hold c%0d got %h want %h", c, out_a(), prev); else passed++;
      end
      held = ifa.m_axis_tvalid && !ifa.m_axis_tready;
      prev = out_a();
      if (held) begin
        total++; if (ifa.s_axis_tready !== 4'b0) $display("FAIL bp_stall_ready c%0d got %b want 0000", c, ifa.s_axis_tready); else passed++;
      end
      if (ifa.m_axis_tvalid && ifa.m_axis_tready) begin
        p = int'(ifa.m_axis_tdata[63:48]);
        total++;
        if (p >= N || (open_p >= 0 && p != open_p)) begin
          $display("FAIL bp_port beat%0d got port %0d want open port %0d", got, p, open_p);
        end else begin
          exp = beat_of(p, sb_pkt[p], sb_beat[p], sb_beat[p] == lens[p][sb_pkt[p]] - 1);
          if (out_a() !== exp) $display("FAIL bp_beat%0d got %h want %h", got, out_a(), exp);
          else passed++;
          open_p = ifa.m_axis_tlast ? -1 : p;
          if (sb_beat[p] == lens[p][sb_pkt[p]] - 1) begin sb_pkt[p]++; sb_beat[p] = 0; end
          else sb_beat[p]++;
          if (sb_pkt[p] >= 500) sb_pkt[p] = 499;
        end
        got++;
      end
      next_cycle();
      ifa.m_axis_tready = 1'($urandom_range(0, 1));
      ifb.m_axis_tready = ifa.m_axis_tready;
      for (int q = 0; q < N; q++) begin
        if (hs[q]) begin
          if (src_beat[q] == lens[q][src_pkt[q]] - 1) begin src_pkt[q]++; src_beat[q] = 0; end
          else src_beat[q]++;
          drive(q, 1'b0, 0, 0, 1'b0);
        end
        if (!ifa.s_axis_tvalid[q] && src_pkt[q] < 500 && $urandom_range(0, 3) != 0)
          drive(q, 1'b1, src_pkt[q], src_beat[q], src_beat[q] == lens[q][src_pkt[q]] - 1);
      end
    end
    total++; if (got != need) $display("FAIL bp_beat_count got %0d want %0d", got, need); else passed++;
    for (int q = 0; q < N; q++) begin
      total++; if (cnt_a[q*32 +: 32] !== 32'd500) $display("FAIL bp_pkt_cnt%0d got %0d want 500", q, cnt_a[q*32 +: 32]); else passed++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(1, 1'b1, 0, 0, 1'b1);
    next_cycle();
    drive(1, 1'b0, 0, 0, 1'b0);
    next_cycle();
    @(negedge clk);
    total++; if (cnt_a[32 +: 32] !== 32'd1) $display("FAIL rmid_pre_cnt1 got %0d want 1", cnt_a[32 +: 32]); else passed++;
    next_cycle();
    drive(1, 1'b1, 1, 0, 1'b0);
    next_cycle();
    drive(1, 1'b1, 1, 1, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    total++; if (ifa.s_axis_tready !== 4'b0) $display("FAIL rmid_ready_in_reset got %b want 0000", ifa.s_axis_tready); else passed++;
    next_cycle();
    aresetn = 1'b1;
    drive(1, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    total++; if (ifa.m_axis_tvalid !== 1'b0 || out_a() !== '0) $display("FAIL rmid_out got v%b %h want v0 0", ifa.m_axis_tvalid, out_a()); else passed++;
    total++; if (grant_a !== 2'd0 || busy_a !== 1'b0) $display("FAIL rmid_state got grant %0d busy %b want 0 0", grant_a, busy_a); else passed++;
    total++; if (cnt_a !== '0) $display("FAIL rmid_pkt_cnt got %h want 0", cnt_a); else passed++;
    next_cycle();
    drive(3, 1'b1, 0, 0, 1'b1);
    @(negedge clk);
    total++; if (ifa.s_axis_tready !== 4'b1000) $display("FAIL rmid_new_start_ready got %b want 1000", ifa.s_axis_tready); else passed++;
    next_cycle();
    drive(3, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    total++; if (ifa.m_axis_tvalid !== 1'b1 || out_a() !== beat_of(3, 0, 0, 1'b1)) $display("FAIL rmid_new_beat got %h want %h", out_a(), beat_of(3, 0, 0, 1'b1)); else passed++;
    total++; if (grant_a !== 2'd3 || cnt_a[96 +: 32] !== 32'd1) $display("FAIL rmid_new_grant got grant %0d cnt3 %0d want 3 1", grant_a, cnt_a[96 +: 32]); else passed++;
    next_cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim time expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_atomicity();
    test_ctrl_prio();
    test_backpressure();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
